// File: rtl/hazard_ctrl_unit.sv
// Hazard detection and operand forwarding for the 5-stage MIPS pipeline, including the
// multi-cycle mul/div occupancy sequencer and saturating stall-cycle counters.
//
// state | meaning
// IDLE  | no mul/div op in E; a start stalls this cycle and loads the down-counter
// BUSY  | mul/div op occupying E; stall while cnt != 0, the cnt == 0 cycle is the done cycle
module hazard_ctrl_unit #(
    parameter int MULDIV_LAT = 4,
    parameter int CNT_W      = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [4:0]       rsD,
    input  logic [4:0]       rtD,
    input  logic             BranchD,
    input  logic [4:0]       rsE,
    input  logic [4:0]       rtE,
    input  logic [4:0]       WriteRegE,
    input  logic             RegWriteE,
    input  logic             MemToRegE,
    input  logic             MulDivStartE,
    input  logic [4:0]       WriteRegM,
    input  logic             RegWriteM,
    input  logic             MemToRegM,
    input  logic [4:0]       WriteRegW,
    input  logic             RegWriteW,
    output logic             StallF,
    output logic             StallD,
    output logic             FlushE,
    output logic             StallE,
    output logic             FlushM,
    output logic             ForwardAD,
    output logic             ForwardBD,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             MulDivDoneE,
    output logic [CNT_W-1:0] LoadStallCnt,
    output logic [CNT_W-1:0] BranchStallCnt,
    output logic [CNT_W-1:0] MulDivStallCnt
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mdState_t;

    localparam logic [3:0]       LAT_M2  = 4'(MULDIV_LAT - 2);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    mdState_t   state;
    logic [3:0] cnt;
    logic       doneQ;
    logic       lwStall;
    logic       brStall;
    logic       mdStall;

    // A zero source tag never matches: r0 is hardwired and cannot carry a hazard.
    function automatic logic tagHit(input logic [4:0] src, input logic [4:0] dst);
        return (src != 5'd0) && (src == dst);
    endfunction

    always_comb begin
        ForwardAE = 2'b00;
        if (RegWriteM && tagHit(rsE, WriteRegM))
            ForwardAE = 2'b10;
        else if (RegWriteW && tagHit(rsE, WriteRegW))
            ForwardAE = 2'b01;
    end

    always_comb begin
        ForwardBE = 2'b00;
        if (RegWriteM && tagHit(rtE, WriteRegM))
            ForwardBE = 2'b10;
        else if (RegWriteW && tagHit(rtE, WriteRegW))
            ForwardBE = 2'b01;
    end

    assign ForwardAD = RegWriteM & tagHit(rsD, WriteRegM);
    assign ForwardBD = RegWriteM & tagHit(rtD, WriteRegM);

    assign lwStall = MemToRegE & (tagHit(rsD, rtE) | tagHit(rtD, rtE));

    assign brStall = BranchD &
                     ((RegWriteE & (tagHit(rsD, WriteRegE) | tagHit(rtD, WriteRegE))) |
                      (MemToRegM & (tagHit(rsD, WriteRegM) | tagHit(rtD, WriteRegM))));

    // Reset forces mdStall low so an aborted op releases E in the reset cycle itself.
    assign mdStall = ~RST & (((state == IDLE) & MulDivStartE) |
                             ((state == BUSY) & (cnt != 4'd0)));

    assign StallF      = lwStall | brStall | mdStall;
    assign StallD      = lwStall | brStall | mdStall;
    assign StallE      = mdStall;
    assign FlushM      = mdStall;
    assign FlushE      = (lwStall | brStall) & ~mdStall;
    assign MulDivDoneE = doneQ;

    // doneQ is precomputed so it is high exactly while BUSY with cnt == 0.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
            cnt   <= 4'd0;
            doneQ <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (MulDivStartE) begin
                        state <= BUSY;
                        cnt   <= LAT_M2;
                        doneQ <= (LAT_M2 == 4'd0);
                    end else begin
                        doneQ <= 1'b0;
                    end
                end
                BUSY: begin
                    if (cnt != 4'd0) begin
                        cnt   <= cnt - 4'd1;
                        doneQ <= (cnt == 4'd1);
                    end else begin
                        state <= IDLE;
                        doneQ <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= 4'd0;
                    doneQ <= 1'b0;
                end
            endcase
        end
    end

    // A cycle that is both a load and a branch stall is attributed to the load only.
    always_ff @(posedge CLK) begin
        if (RST) begin
            LoadStallCnt   <= '0;
            BranchStallCnt <= '0;
            MulDivStallCnt <= '0;
        end else begin
            if (mdStall && (MulDivStallCnt != CNT_MAX))
                MulDivStallCnt <= MulDivStallCnt + CNT_ONE;
            if (lwStall && !mdStall && (LoadStallCnt != CNT_MAX))
                LoadStallCnt <= LoadStallCnt + CNT_ONE;
            if (brStall && !lwStall && !mdStall && (BranchStallCnt != CNT_MAX))
                BranchStallCnt <= BranchStallCnt + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Directed bench for hazard_ctrl_unit: a default instance plus a narrow-counter,
// minimum-latency instance sharing the same stimulus.
module tb_hazard_ctrl_unit;

    logic       CLK = 1'b0;
    logic       RST;
    logic [4:0] rsD, rtD, rsE, rtE, WriteRegE, WriteRegM, WriteRegW;
    logic       BranchD, RegWriteE, MemToRegE, MulDivStartE;
    logic       RegWriteM, MemToRegM, RegWriteW;

    logic        StallF, StallD, FlushE, StallE, FlushM, ForwardAD, ForwardBD, MulDivDoneE;
    logic [1:0]  ForwardAE, ForwardBE;
    logic [15:0] LoadStallCnt, BranchStallCnt, MulDivStallCnt;

    logic        sStallF, sStallD, sFlushE, sStallE, sFlushM, sForwardAD, sForwardBD, sMulDivDoneE;
    logic [1:0]  sForwardAE, sForwardBE;
    logic [3:0]  sLoadStallCnt, sBranchStallCnt, sMulDivStallCnt;

    int nVec  = 0;
    int nFail = 0;

    hazard_ctrl_unit #(.MULDIV_LAT(4), .CNT_W(16)) dut (
        .CLK(CLK), .RST(RST), .rsD(rsD), .rtD(rtD), .BranchD(BranchD),
        .rsE(rsE), .rtE(rtE), .WriteRegE(WriteRegE), .RegWriteE(RegWriteE),
        .MemToRegE(MemToRegE), .MulDivStartE(MulDivStartE),
        .WriteRegM(WriteRegM), .RegWriteM(RegWriteM), .MemToRegM(MemToRegM),
        .WriteRegW(WriteRegW), .RegWriteW(RegWriteW),
        .StallF(StallF), .StallD(StallD), .FlushE(FlushE), .StallE(StallE), .FlushM(FlushM),
        .ForwardAD(ForwardAD), .ForwardBD(ForwardBD), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .MulDivDoneE(MulDivDoneE), .LoadStallCnt(LoadStallCnt),
        .BranchStallCnt(BranchStallCnt), .MulDivStallCnt(MulDivStallCnt)
    );

    hazard_ctrl_unit #(.MULDIV_LAT(2), .CNT_W(4)) dutSat (
        .CLK(CLK), .RST(RST), .rsD(rsD), .rtD(rtD), .BranchD(BranchD),
        .rsE(rsE), .rtE(rtE), .WriteRegE(WriteRegE), .RegWriteE(RegWriteE),
        .MemToRegE(MemToRegE), .MulDivStartE(MulDivStartE),
        .WriteRegM(WriteRegM), .RegWriteM(RegWriteM), .MemToRegM(MemToRegM),
        .WriteRegW(WriteRegW), .RegWriteW(RegWriteW),
        .StallF(sStallF), .StallD(sStallD), .FlushE(sFlushE), .StallE(sStallE), .FlushM(sFlushM),
        .ForwardAD(sForwardAD), .ForwardBD(sForwardBD), .ForwardAE(sForwardAE), .ForwardBE(sForwardBE),
        .MulDivDoneE(sMulDivDoneE), .LoadStallCnt(sLoadStallCnt),
        .BranchStallCnt(sBranchStallCnt), .MulDivStallCnt(sMulDivStallCnt)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic clearIn();
        rsD = 0; rtD = 0; rsE = 0; rtE = 0; WriteRegE = 0; WriteRegM = 0; WriteRegW = 0;
        BranchD = 0; RegWriteE = 0; MemToRegE = 0; MulDivStartE = 0;
        RegWriteM = 0; MemToRegM = 0; RegWriteW = 0;
    endtask

    task automatic doReset();
        clearIn();
        RST = 1'b1;
        tick();
        tick();
        RST = 1'b0;
    endtask

    task automatic test_reset();
        doReset();
        RST = 1'b1;
        MulDivStartE = 1; RegWriteM = 1; WriteRegM = 8; rsE = 8;
        #1;
        nVec++; if (StallE !== 1'b0) begin nFail++; $display("FAIL rst_stallE got %b exp 0", StallE); end
        nVec++; if (ForwardAE !== 2'b10) begin nFail++; $display("FAIL rst_fwdAE got %b exp 10", ForwardAE); end
        tick();
        nVec++; if (MulDivDoneE !== 1'b0) begin nFail++; $display("FAIL rst_done got %b exp 0", MulDivDoneE); end
        nVec++; if ({LoadStallCnt, BranchStallCnt, MulDivStallCnt} !== 48'd0) begin
            nFail++; $display("FAIL rst_cnts got %0d/%0d/%0d exp 0/0/0", LoadStallCnt, BranchStallCnt, MulDivStallCnt); end
        RST = 1'b0;
        clearIn();
    endtask

    task automatic test_forwarding();
        doReset();
        RegWriteM = 1; WriteRegM = 8; RegWriteW = 1; WriteRegW = 8; rsE = 8; rtE = 9;
        #1;
        nVec++; if (ForwardAE !== 2'b10) begin nFail++; $display("FAIL fwd_m_prio got %b exp 10", ForwardAE); end
        nVec++; if (ForwardBE !== 2'b00) begin nFail++; $display("FAIL fwd_b_none got %b exp 00", ForwardBE); end
        RegWriteM = 0;
        #1;
        nVec++; if (ForwardAE !== 2'b01) begin nFail++; $display("FAIL fwd_w got %b exp 01", ForwardAE); end
        WriteRegW = 9;
        #1;
        nVec++; if (ForwardBE !== 2'b01) begin nFail++; $display("FAIL fwd_bw got %b exp 01", ForwardBE); end
        RegWriteM = 1; WriteRegM = 0; WriteRegW = 0; rsE = 0;
        #1;
        nVec++; if (ForwardAE !== 2'b00) begin nFail++; $display("FAIL fwd_r0 got %b exp 00", ForwardAE); end
        clearIn();
    endtask

    task automatic test_load_use();
        doReset();
        MemToRegE = 1; rtE = 5; rsD = 5;
        #1;
        nVec++; if ({StallF, StallD, FlushE, StallE} !== 4'b1110) begin
            nFail++; $display("FAIL lw_stall got F/D/FE/E=%b exp 1110", {StallF, StallD, FlushE, StallE}); end
        tick();
        nVec++; if (LoadStallCnt !== 16'd1) begin nFail++; $display("FAIL lw_cnt got %0d exp 1", LoadStallCnt); end
        rsD = 6; rtD = 6;
        #1;
        nVec++; if ({StallF, FlushE} !== 2'b00) begin nFail++; $display("FAIL lw_nohit got %b exp 00", {StallF, FlushE}); end
        rtE = 0; rsD = 0; rtD = 0;
        #1;
        nVec++; if (StallF !== 1'b0) begin nFail++; $display("FAIL lw_r0 got %b exp 0", StallF); end
        tick();
        nVec++; if (LoadStallCnt !== 16'd1) begin nFail++; $display("FAIL lw_cnt_hold got %0d exp 1", LoadStallCnt); end
        clearIn();
    endtask

    task automatic test_branch();
        doReset();
        BranchD = 1; RegWriteE = 1; WriteRegE = 3; rsD = 3;
        #1;
        nVec++; if ({StallF, FlushE} !== 2'b11) begin nFail++; $display("FAIL br_e got %b exp 11", {StallF, FlushE}); end
        tick();
        nVec++; if (BranchStallCnt !== 16'd1) begin nFail++; $display("FAIL br_cnt1 got %0d exp 1", BranchStallCnt); end
        RegWriteE = 0; WriteRegE = 0; RegWriteM = 1; WriteRegM = 3; MemToRegM = 0;
        #1;
        nVec++; if ({StallF, ForwardAD} !== 2'b01) begin nFail++; $display("FAIL br_fwd got %b exp 01", {StallF, ForwardAD}); end
        tick();
        MemToRegM = 1;
        #1;
        nVec++; if ({StallF, FlushE} !== 2'b11) begin nFail++; $display("FAIL br_m_load got %b exp 11", {StallF, FlushE}); end
        tick();
        nVec++; if (BranchStallCnt !== 16'd2) begin nFail++; $display("FAIL br_cnt2 got %0d exp 2", BranchStallCnt); end
        MemToRegE = 1; rtE = 3;
        tick();
        nVec++; if ({LoadStallCnt, BranchStallCnt} !== {16'd1, 16'd2}) begin
            nFail++; $display("FAIL br_lw_overlap got %0d/%0d exp 1/2", LoadStallCnt, BranchStallCnt); end
        clearIn();
    endtask

    task automatic test_muldiv();
        doReset();
        MulDivStartE = 1; MemToRegE = 1; rtE = 5; rsD = 5;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) begin MemToRegE = 0; rtE = 0; rsD = 0; end
            #1;
            nVec++; if ({StallE, FlushM, MulDivDoneE} !== ((i < 3) ? 3'b110 : 3'b001)) begin
                nFail++; $display("FAIL md_cyc%0d got E/M/done=%b", i, {StallE, FlushM, MulDivDoneE}); end
            if (i < 3) begin
                nVec++; if ({FlushE, StallF} !== 2'b01) begin nFail++; $display("FAIL md_noflush%0d got %b exp 01", i, {FlushE, StallF}); end
            end
            if (i == 0) begin
                nVec++; if (sStallE !== 1'b1) begin nFail++; $display("FAIL md2_stall got %b exp 1", sStallE); end
            end
            if (i == 1) begin
                nVec++; if ({sStallE, sMulDivDoneE} !== 2'b01) begin nFail++; $display("FAIL md2_done got %b exp 01", {sStallE, sMulDivDoneE}); end
            end
            if (i == 3) MulDivStartE = 0;
            tick();
        end
        nVec++; if ({MulDivStallCnt, LoadStallCnt} !== {16'd3, 16'd0}) begin
            nFail++; $display("FAIL md_cnts got %0d/%0d exp 3/0", MulDivStallCnt, LoadStallCnt); end
        nVec++; if ({StallE, MulDivDoneE} !== 2'b00) begin nFail++; $display("FAIL md_idle got %b exp 00", {StallE, MulDivDoneE}); end
        clearIn();
    endtask

    task automatic test_reset_midop();
        doReset();
        MulDivStartE = 1;
        tick();
        tick();
        RST = 1'b1;
        #1;
        nVec++; if (StallE !== 1'b0) begin nFail++; $display("FAIL rmid_rst_stall got %b exp 0", StallE); end
        tick();
        RST = 1'b0; MulDivStartE = 0;
        #1;
        nVec++; if ({StallE, MulDivDoneE} !== 2'b00) begin nFail++; $display("FAIL rmid_idle got %b exp 00", {StallE, MulDivDoneE}); end
        nVec++; if (MulDivStallCnt !== 16'd0) begin nFail++; $display("FAIL rmid_cnt got %0d exp 0", MulDivStallCnt); end
        MulDivStartE = 1;
        for (int i = 0; i < 4; i++) begin
            #1;
            nVec++; if ({StallE, MulDivDoneE} !== ((i < 3) ? 2'b10 : 2'b01)) begin
                nFail++; $display("FAIL rmid_cyc%0d got E/done=%b", i, {StallE, MulDivDoneE}); end
            if (i == 3) MulDivStartE = 0;
            tick();
        end
        nVec++; if (MulDivStallCnt !== 16'd3) begin nFail++; $display("FAIL rmid_cnt3 got %0d exp 3", MulDivStallCnt); end
        clearIn();
    endtask

    task automatic test_saturation();
        doReset();
        MemToRegE = 1; rtE = 5; rsD = 5;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (i == 15) begin
                nVec++; if (sLoadStallCnt !== 4'd15) begin nFail++; $display("FAIL sat_reach got %0d exp 15", sLoadStallCnt); end
            end
        end
        nVec++; if (sLoadStallCnt !== 4'd15) begin nFail++; $display("FAIL sat_hold got %0d exp 15", sLoadStallCnt); end
        nVec++; if (LoadStallCnt !== 16'd20) begin nFail++; $display("FAIL sat_wide got %0d exp 20", LoadStallCnt); end
        clearIn();
    endtask

    initial begin
        clearIn();
        RST = 1'b1;
        test_reset();
        test_forwarding();
        test_load_use();
        test_branch();
        test_muldiv();
        test_reset_midop();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl_unit.md
Name: hazard_ctrl_unit

Overview:
- Hazard and forwarding controller for the 5-stage MIPS pipeline.
- Consumes the register tags and control bits that the D/E/M/W pipeline registers present.
- Drives FlushE into the ID/EX register, stall enables for the F/D registers, and the forwarding mux selects.
- Adds a multi-cycle mul/div occupancy FSM that holds E and bubbles M, plus saturating stall-cycle performance counters.

Parameters:
- MULDIV_LAT, 4, total cycles a mul/div op occupies E; legal range 2..16.
- CNT_W, 16, width of each performance counter.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RST  input  1  synchronous active-high reset.
- rsD  input  5  source register A of the instruction in D.
- rtD  input  5  source register B of the instruction in D.
- BranchD  input  1  instruction in D is a branch resolved in D.
- rsE  input  5  source register A of the instruction in E.
- rtE  input  5  source register B of the instruction in E.
- WriteRegE  input  5  destination register of the instruction in E.
- RegWriteE  input  1  register-write enable of the instruction in E.
- MemToRegE  input  1  instruction in E is a load.
- MulDivStartE  input  1  instruction in E is a multi-cycle mul/div.
- WriteRegM  input  5  destination register of the instruction in M.
- RegWriteM  input  1  register-write enable of the instruction in M.
- MemToRegM  input  1  instruction in M is a load.
- WriteRegW  input  5  destination register of the instruction in W.
- RegWriteW  input  1  register-write enable of the instruction in W.
- StallF  output  1  hold the PC.
- StallD  output  1  hold the IF/ID register.
- FlushE  output  1  bubble the ID/EX register.
- StallE  output  1  hold the ID/EX register.
- FlushM  output  1  bubble the EX/MEM register.
- ForwardAD  output  1  branch comparator A operand takes the ALU result from M.
- ForwardBD  output  1  branch comparator B operand takes the ALU result from M.
- ForwardAE  output  2  ALU SrcA select: 00 = register file, 01 = W result, 10 = M ALU result.
- ForwardBE  output  2  ALU SrcB select, same encoding as ForwardAE.
- MulDivDoneE  output  1  final cycle of a mul/div op in E.
- LoadStallCnt  output  CNT_W  number of load-use stall cycles.
- BranchStallCnt  output  CNT_W  number of branch stall cycles.
- MulDivStallCnt  output  CNT_W  number of mul/div stall cycles.

Behaviour:
- Register 0 is never a hazard source: any tag comparison against a zero source tag is false.
- ForwardAE (combinational): 10 if RegWriteM and WriteRegM==rsE; else 01 if RegWriteW and WriteRegW==rsE; else 00. The M match wins over a simultaneous W match. ForwardBE is identical using rtE.
- ForwardAD = RegWriteM & (WriteRegM==rsD). ForwardBD is the same using rtD. Both are combinational.
- lwstall = MemToRegE & ((rtE==rsD) | (rtE==rtD)), with the zero-tag rule applied.
- brstall = BranchD & ((RegWriteE & WriteRegE matches rsD or rtD) | (MemToRegM & WriteRegM matches rsD or rtD)).
- Mul/div FSM states are IDLE and BUSY, with a down-counter cnt.
  - IDLE with MulDivStartE: mdstall=1; cnt<=MULDIV_LAT-2; next state BUSY.
  - BUSY with cnt!=0: mdstall=1; cnt decrements.
  - BUSY with cnt==0: mdstall=0; MulDivDoneE=1; next state IDLE.
  - MulDivStartE is ignored while in BUSY.
  - Result: LAT-1 stall cycles followed by one done cycle, so the op occupies E for exactly MULDIV_LAT cycles.
- Output equations:
  - StallF = StallD = lwstall | brstall | mdstall.
  - StallE = FlushM = mdstall.
  - FlushE = (lwstall | brstall) & ~mdstall. FlushE must never kill a held mul/div.
  - FlushE and StallE are never both 1.
- Counters update each cycle and saturate at all-ones (no wrap):
  - MulDivStallCnt += mdstall.
  - LoadStallCnt += lwstall & ~mdstall.
  - BranchStallCnt += brstall & ~lwstall & ~mdstall. A cycle with both lwstall and brstall counts as a load stall only.
- Reset: state IDLE, cnt 0, all counters 0, MulDivDoneE 0.
  - Combinational outputs follow their inputs during reset, except mdstall, which is 0.
  - RST while in BUSY aborts the op: the next cycle is IDLE with no stall.
- All stall, flush and forward outputs are combinational from the inputs and FSM state, so a hazard is acted on in the cycle it is presented. There is no added latency.

Test Plan:
- Forwarding priority: RegWriteM=1, WriteRegM=8, RegWriteW=1, WriteRegW=8, rsE=8, rtE=9 -> ForwardAE=10, ForwardBE=00. Then drop RegWriteM -> ForwardAE=01. Then set rsE=0 with both tags 0 -> ForwardAE=00.
- Load-use: MemToRegE=1, rtE=5, rsD=5 -> StallF=StallD=FlushE=1 for one cycle, LoadStallCnt 0->1. With rsD=rtD=6 -> no stall.
- Branch hazards:
  - BranchD=1, RegWriteE=1, WriteRegE=3, rsD=3 -> stall plus FlushE.
  - Next cycle, same tag on MemToRegM=0, RegWriteM=1 -> no stall, ForwardAD=1.
  - Same tag with MemToRegM=1 -> stall.
- Mul/div, MULDIV_LAT=4: MulDivStartE held high -> StallE=FlushM=1 for 3 cycles, MulDivDoneE=1 on the 4th, MulDivStallCnt=3. Raising lwstall during this window -> FlushE stays 0 and LoadStallCnt is unchanged.
- Reset mid-op: assert RST in the 2nd BUSY cycle -> next cycle StallE=0, all counters 0. A fresh MulDivStartE then restarts the full 4-cycle sequence.
- Saturation: CNT_W=4, hold lwstall for 20 cycles -> LoadStallCnt reaches 15 and stays at 15.
